// File: rtl/instr_fetcher_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetcher.
package instr_fetcher_pkg;

  localparam int unsigned LEN_WORD         = 32;
  localparam logic [LEN_WORD-1:0] WORD_ZERO = '0;
  localparam int unsigned FETCH_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_FILL_D = 2'd1,
    FETCH_FILL_P = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetcher_if.sv
// Fetch handshake plus BRAM read port seen by the fetcher (slave) and its environment (master).
interface instr_fetcher_if
  import instr_fetcher_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = 15
);

  logic                  fetch_order;
  logic [LEN_WORD-1:0]   fetch_pc;
  logic                  fetch_done;
  logic [LEN_WORD-1:0]   fetch_instr;
  logic [LEN_WORD-1:0]   fetch_hint;
  logic                  mem_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LEN_WORD-1:0]   mem_rdata;

  modport master (
    output fetch_order, fetch_pc, fetch_hint, mem_rdata,
    input  fetch_done, fetch_instr, mem_en, mem_addr
  );

  modport slave (
    input  fetch_order, fetch_pc, fetch_hint, mem_rdata,
    output fetch_done, fetch_instr, mem_en, mem_addr
  );

endinterface

// File: rtl/instr_fetcher_line_buf.sv
// One instruction line entry: valid/tag, word array with a write port, lookup and hint probe.
module instr_fetcher_line_buf
  import instr_fetcher_pkg::*;
#(
  parameter int unsigned LINE_WORDS = FETCH_LINE_WORDS,
  parameter int unsigned TAG_W      = 13
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_init,
  input  logic                          i_clr,
  input  logic                          i_set,
  input  logic [TAG_W-1:0]              i_set_tag,
  input  logic                          i_wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_idx,
  input  logic [LEN_WORD-1:0]           i_wr_data,
  input  logic [TAG_W-1:0]              i_lookup_tag,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_off,
  input  logic [TAG_W-1:0]              i_probe_tag,
  output logic                          o_hit_c,
  output logic                          o_probe_hit_c,
  output logic [LEN_WORD-1:0]           o_rd_data_c
);

  logic                r_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [LEN_WORD-1:0] r_data [LINE_WORDS];

  // Completion (set) wins over a same-cycle clear; flush wins over both.
  always_ff @(posedge clk) begin
    if (!rstn || i_init) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_tag   <= i_set_tag;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_data[i_wr_idx] <= i_wr_data;
  end

  assign o_hit_c       = r_valid && (r_tag == i_lookup_tag);
  assign o_probe_hit_c = r_valid && (r_tag == i_probe_tag);
  assign o_rd_data_c   = r_data[i_rd_off];

endmodule

// File: rtl/instr_fetcher.sv
// Two-entry line-buffered instruction fetcher: same-cycle hits, demand fills and hint prefetch from a 1-cycle BRAM.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = FETCH_LINE_WORDS,
  parameter int unsigned MEM_ADDR_W  = 15,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input logic            clk,
  input logic            rstn,
  input logic            init,
  instr_fetcher_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = MEM_ADDR_W - OFF_W;
  localparam int unsigned CNT_W = OFF_W + 1;

  fetch_state_e          r_state, w_state_nxt;
  logic [TAG_W-1:0]      r_fill_tag, w_fill_tag_nxt, w_start_tag;
  logic                  r_fill_entry, w_fill_entry_nxt;
  logic [CNT_W-1:0]      r_issue_cnt, w_issue_cnt_nxt;
  logic [OFF_W-1:0]      r_recv_cnt, w_recv_cnt_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic [MEM_ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_rcv_vld, r_lru;
  logic                  w_flush, w_start, w_abort, w_wr, w_last_wr, w_miss, w_done;
  logic [MEM_ADDR_W-1:0] w_wa;
  logic [TAG_W-1:0]      w_pc_tag, w_hint_tag;
  logic [OFF_W-1:0]      w_pc_off;
  logic [1:0]            w_hit, w_probe_hit;
  logic [LEN_WORD-1:0]   w_rd_data [2];
  logic                  w_unused_bits;

  assign w_wa       = bus.fetch_pc[MEM_ADDR_W+1:2];
  assign w_pc_tag   = w_wa[MEM_ADDR_W-1:OFF_W];
  assign w_pc_off   = w_wa[OFF_W-1:0];
  assign w_hint_tag = bus.fetch_hint[MEM_ADDR_W+1:OFF_W+2];

  assign w_unused_bits = ^{bus.fetch_pc[1:0], bus.fetch_pc[LEN_WORD-1:MEM_ADDR_W+2],
                           bus.fetch_hint[OFF_W+1:0], bus.fetch_hint[LEN_WORD-1:MEM_ADDR_W+2]};

  assign w_flush   = !rstn || init;
  assign w_miss    = bus.fetch_order && !(|w_hit);
  assign w_done    = bus.fetch_order && (|w_hit) && !w_flush;
  assign w_wr      = r_rcv_vld && (r_state != FETCH_IDLE) && !w_flush;
  assign w_last_wr = w_wr && (r_recv_cnt == OFF_W'(LINE_WORDS - 1));

  for (genvar e = 0; e < 2; e++) begin : g_line
    instr_fetcher_line_buf #(
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
    ) u_line (
      .clk           (clk),
      .rstn          (rstn),
      .i_init        (init),
      .i_clr         (w_start && (r_lru == 1'(e))),
      .i_set         (w_last_wr && (r_fill_entry == 1'(e))),
      .i_set_tag     (r_fill_tag),
      .i_wr_en       (w_wr && (r_fill_entry == 1'(e))),
      .i_wr_idx      (r_recv_cnt),
      .i_wr_data     (bus.mem_rdata),
      .i_lookup_tag  (w_pc_tag),
      .i_rd_off      (w_pc_off),
      .i_probe_tag   (w_hint_tag),
      .o_hit_c       (w_hit[e]),
      .o_probe_hit_c (w_probe_hit[e]),
      .o_rd_data_c   (w_rd_data[e])
    );
  end

  // Next state, fill bookkeeping and the registered BRAM request.
  always_comb begin
    w_state_nxt      = r_state;
    w_fill_tag_nxt   = r_fill_tag;
    w_fill_entry_nxt = r_fill_entry;
    w_issue_cnt_nxt  = r_issue_cnt;
    w_recv_cnt_nxt   = r_recv_cnt;
    w_mem_en_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_start          = 1'b0;
    w_abort          = 1'b0;
    w_start_tag      = w_pc_tag;

    unique case (r_state)
      FETCH_IDLE: begin
        if (w_miss) begin
          w_start     = 1'b1;
          w_state_nxt = FETCH_FILL_D;
        end else if (PREFETCH_EN && !(|w_probe_hit) &&
                     !(bus.fetch_order && (w_hint_tag == w_pc_tag))) begin
          w_start     = 1'b1;
          w_start_tag = w_hint_tag;
          w_state_nxt = FETCH_FILL_P;
        end
      end
      FETCH_FILL_D: begin
        if (w_last_wr) w_state_nxt = FETCH_IDLE;
      end
      FETCH_FILL_P: begin
        if (w_last_wr) begin
          w_state_nxt = FETCH_IDLE;
        end else if (w_miss && (w_pc_tag != r_fill_tag)) begin
          w_abort     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = FETCH_FILL_D;
        end
      end
      default: w_state_nxt = FETCH_IDLE;
    endcase

    if (r_state != FETCH_IDLE) begin
      if (r_issue_cnt < CNT_W'(LINE_WORDS)) begin
        w_mem_en_nxt    = 1'b1;
        w_mem_addr_nxt  = {r_fill_tag, r_issue_cnt[OFF_W-1:0]};
        w_issue_cnt_nxt = r_issue_cnt + CNT_W'(1);
      end
      if (w_wr) w_recv_cnt_nxt = r_recv_cnt + OFF_W'(1);
      if (w_last_wr) begin
        w_issue_cnt_nxt = '0;
        w_recv_cnt_nxt  = '0;
      end
    end

    // A new fill issues word 0 straight away so mem_en rises the next cycle.
    if (w_start) begin
      w_fill_tag_nxt   = w_start_tag;
      w_fill_entry_nxt = r_lru;
      w_issue_cnt_nxt  = CNT_W'(1);
      w_recv_cnt_nxt   = '0;
      w_mem_en_nxt     = 1'b1;
      w_mem_addr_nxt   = {w_start_tag, OFF_W'(0)};
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state      <= FETCH_IDLE;
      r_fill_tag   <= '0;
      r_fill_entry <= 1'b0;
      r_issue_cnt  <= '0;
      r_recv_cnt   <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_rcv_vld    <= 1'b0;
      r_lru        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_tag   <= w_fill_tag_nxt;
      r_fill_entry <= w_fill_entry_nxt;
      r_issue_cnt  <= w_issue_cnt_nxt;
      r_recv_cnt   <= w_recv_cnt_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      // The word still in flight from an aborted prefetch is dropped.
      r_rcv_vld    <= r_mem_en && !w_abort;
      if (w_done) r_lru <= w_hit[0];
    end
  end

  assign bus.fetch_done  = w_done;
  assign bus.fetch_instr = w_done ? (w_hit[0] ? w_rd_data[0] : w_rd_data[1]) : WORD_ZERO;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: vector table for fills, hits and LRU, plus prefetch/abort/init sequences.
module tb_instr_fetcher;
  import instr_fetcher_pkg::*;

  localparam int unsigned AW = 15;

  logic clk;
  logic rstn;
  logic init;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetcher_if #(.MEM_ADDR_W(AW)) bus ();

  instr_fetcher #(
    .LINE_WORDS  (4),
    .MEM_ADDR_W  (AW),
    .PREFETCH_EN (1'b1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .init (init),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM with contents mem[w] = 0x1000 + w and one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= 32'h1000 + 32'(bus.mem_addr);
  end

  typedef struct {
    logic          order;
    logic [31:0]   pc;
    logic          ed;
    logic [31:0]   ei;
    logic          ee;
    logic [AW-1:0] ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic o, input logic [31:0] pc, input logic ed,
                             input logic [31:0] ei, input logic ee, input logic [AW-1:0] ea);
    vec_t r;
    r.order = o;
    r.pc    = pc;
    r.ed    = ed;
    r.ei    = ei;
    r.ee    = ee;
    r.ea    = ea;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic o, input logic [31:0] pc, input logic [31:0] hint, input logic in);
    bus.fetch_order = o;
    bus.fetch_pc    = pc;
    bus.fetch_hint  = hint;
    init            = in;
  endtask

  // Sample mid-cycle, then move to just after the next rising edge.
  task automatic cyc(input string nm, input logic ed, input logic [31:0] ei,
                     input logic ee, input logic [AW-1:0] ea);
    @(negedge clk);
    cmp({nm, ".done"},   32'(bus.fetch_done), 32'(ed));
    cmp({nm, ".instr"},  bus.fetch_instr, ei);
    cmp({nm, ".mem_en"}, 32'(bus.mem_en), 32'(ee));
    if (ee) cmp({nm, ".mem_addr"}, 32'(bus.mem_addr), 32'(ea));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic o, input logic [31:0] pc, input logic [31:0] hint);
    drv(o, pc, hint, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Cold start, sequential run across a line, revisit, then LRU replacement, with the hint tracking pc.
    tbl.push_back(v(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, AW'(0)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, AW'(k)));
    tbl.push_back(v(1'b1, 32'h0,  1'b0, 32'h0,    1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h0,  1'b1, 32'h1000, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'hC,  1'b1, 32'h1003, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h4,  1'b1, 32'h1001, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h8,  1'b1, 32'h1002, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'hC,  1'b1, 32'h1003, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h10, 1'b0, 32'h0,    1'b0, AW'(0)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, AW'(4 + k)));
    tbl.push_back(v(1'b1, 32'h10, 1'b0, 32'h0,    1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h10, 1'b1, 32'h1004, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h14, 1'b1, 32'h1005, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h18, 1'b1, 32'h1006, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h1C, 1'b1, 32'h1007, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h4,  1'b1, 32'h1001, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h20, 1'b0, 32'h0,    1'b0, AW'(0)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, AW'(8 + k)));
    tbl.push_back(v(1'b1, 32'h20, 1'b0, 32'h0,    1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h20, 1'b1, 32'h1008, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h0,  1'b1, 32'h1000, 1'b0, AW'(0)));
    tbl.push_back(v(1'b1, 32'h10, 1'b0, 32'h0,    1'b0, AW'(0)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1'b0, 32'h10, 1'b0, 32'h0, 1'b1, AW'(4 + k)));
    tbl.push_back(v(1'b0, 32'h10, 1'b0, 32'h0,    1'b0, AW'(0)));

    // Reset state, with a request already pending.
    rstn = 1'b0;
    drv(1'b1, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("rst.done",     32'(bus.fetch_done), 32'h0);
    cmp("rst.instr",    bus.fetch_instr, 32'h0);
    cmp("rst.mem_en",   32'(bus.mem_en), 32'h0);
    cmp("rst.mem_addr", 32'(bus.mem_addr), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    foreach (tbl[i]) begin
      drv(tbl[i].order, tbl[i].pc, tbl[i].pc, 1'b0);
      cyc($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ei, tbl[i].ee, tbl[i].ea);
    end

    // Idle prefetch of hint line 0x40, then a same-cycle hit inside it.
    do_reset(1'b0, 32'h0, 32'h40);
    cyc("pf.idle", 1'b0, 32'h0, 1'b0, AW'(0));
    for (int k = 0; k < 4; k++) cyc("pf.issue", 1'b0, 32'h0, 1'b1, AW'(16 + k));
    cyc("pf.tail", 1'b0, 32'h0, 1'b0, AW'(0));
    cyc("pf.wait", 1'b0, 32'h0, 1'b0, AW'(0));
    drv(1'b1, 32'h48, 32'h40, 1'b0);
    cyc("pf.hit48", 1'b1, 32'h1012, 1'b0, AW'(0));
    drv(1'b1, 32'h40, 32'h40, 1'b0);
    cyc("pf.hit40", 1'b1, 32'h1010, 1'b0, AW'(0));

    // Demand miss on another line during the 2nd prefetch issue aborts the prefetch.
    do_reset(1'b0, 32'h0, 32'h40);
    cyc("ab.idle", 1'b0, 32'h0, 1'b0, AW'(0));
    cyc("ab.pf0",  1'b0, 32'h0, 1'b1, AW'(16));
    drv(1'b1, 32'h80, 32'h80, 1'b0);
    cyc("ab.pf1",  1'b0, 32'h0, 1'b1, AW'(17));
    for (int k = 0; k < 4; k++) cyc("ab.fill", 1'b0, 32'h0, 1'b1, AW'(32 + k));
    cyc("ab.tail", 1'b0, 32'h0, 1'b0, AW'(0));
    cyc("ab.done", 1'b1, 32'h1020, 1'b0, AW'(0));
    drv(1'b1, 32'h40, 32'h80, 1'b0);
    cyc("ab.miss40",   1'b0, 32'h0, 1'b0, AW'(0));
    cyc("ab.refill40", 1'b0, 32'h0, 1'b1, AW'(16));

    // init in the middle of a demand fill flushes both entries; the next order refetches.
    do_reset(1'b1, 32'h0, 32'h0);
    cyc("in.miss", 1'b0, 32'h0, 1'b0, AW'(0));
    for (int k = 0; k < 4; k++) cyc("in.fill", 1'b0, 32'h0, 1'b1, AW'(k));
    cyc("in.tail", 1'b0, 32'h0, 1'b0, AW'(0));
    cyc("in.done", 1'b1, 32'h1000, 1'b0, AW'(0));
    drv(1'b1, 32'h10, 32'h10, 1'b0);
    cyc("in.miss10",  1'b0, 32'h0, 1'b0, AW'(0));
    cyc("in.fill10",  1'b0, 32'h0, 1'b1, AW'(4));
    drv(1'b1, 32'h0, 32'h0, 1'b1);
    cyc("in.initcyc", 1'b0, 32'h0, 1'b1, AW'(5));
    drv(1'b1, 32'h0, 32'h0, 1'b0);
    cyc("in.flushed", 1'b0, 32'h0, 1'b0, AW'(0));
    for (int k = 0; k < 4; k++) cyc("in.refill", 1'b0, 32'h0, 1'b1, AW'(k));
    cyc("in.retail", 1'b0, 32'h0, 1'b0, AW'(0));
    cyc("in.redone", 1'b1, 32'h1000, 1'b0, AW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
